// File: rtl/an_n37_pkg.sv
// Shared constants and types for the A=37 AN-code encoder tile builder.
package an_n37_pkg;
  localparam int AN_A    = 37;
  localparam int MSG_W   = 13;
  localparam int CW_W    = 18;
  localparam int TILE_N  = 16;
  localparam int MSG_MAX = 7084;
  localparam int IDX_W   = 4;

  typedef logic [CW_W-1:0] cw_t;

  typedef enum logic [1:0] {
    FULL_EMPTY = 2'd0,
    FULL_ONE   = 2'd1,
    FULL_TWO   = 2'd2
  } full_state_e;
endpackage

// File: rtl/an_encoder_n37.sv
// Combinational AN encoder: cw = msg * 37 via shift-add; codewords that would
// not fit in 18 bits are zeroed and flagged.
module an_encoder_n37
  import an_n37_pkg::*;
(
  input  logic [MSG_W-1:0] msg,
  output cw_t              cw,
  output logic             ovf
);

  // One spare bit so the product of out-of-range messages cannot wrap.
  logic [CW_W:0] msg_ext;
  logic [CW_W:0] prod;

  assign msg_ext = {{(CW_W + 1 - MSG_W){1'b0}}, msg};
  assign prod    = (msg_ext << 5) + (msg_ext << 2) + msg_ext;
  assign ovf     = (msg > MSG_W'(MSG_MAX));
  assign cw      = ovf ? '0 : prod[CW_W-1:0];

endmodule

// File: rtl/an_encoder_n37_4x4.sv
// Streaming A=37 encoder assembling 16 codewords into double-banked 4x4 tiles.
// Optional single-bit error injection is built when AN_ENC_ERRINJ_EN is defined.
module an_encoder_n37_4x4
  import an_n37_pkg::*;
#(
  parameter int TAG_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [MSG_W-1:0]         in_msg,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [TILE_N*CW_W-1:0]   out_tile,
  output logic [TILE_N-1:0]        out_ovf,
  output logic [TAG_W-1:0]         out_tag
`ifdef AN_ENC_ERRINJ_EN
  ,
  input  logic                     inj_arm,
  input  logic [3:0]               inj_pos,
  input  logic [4:0]               inj_bit
`endif
);

  // state      | meaning
  // FULL_EMPTY | no complete tile; both banks free for filling
  // FULL_ONE   | one tile presented, the other bank filling
  // FULL_TWO   | both banks complete; input stalled until a tile drains

  full_state_e state_q, state_d;

  cw_t              bank_cw  [2][TILE_N];
  logic [TILE_N-1:0] bank_ovf [2];

  logic             wr_bank, rd_bank;
  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] tag_q;

  logic accept, complete, out_hs;
  cw_t  cw_enc, cw_wr;
  logic ovf_enc;

  an_encoder_n37 u_enc (
    .msg (in_msg),
    .cw  (cw_enc),
    .ovf (ovf_enc)
  );

  assign in_ready  = !flush && (state_q != FULL_TWO);
  assign out_valid = (state_q != FULL_EMPTY);
  assign accept    = in_valid && in_ready;
  assign complete  = accept && (wr_idx == IDX_W'(TILE_N - 1));
  assign out_hs    = out_valid && out_ready;
  assign out_tag   = tag_q;
  assign out_ovf   = bank_ovf[rd_bank];

`ifdef AN_ENC_ERRINJ_EN
  logic             armed_q;
  logic [3:0]       inj_pos_q;
  logic [4:0]       inj_bit_q;
  logic             inj_hit;
  cw_t              flip_mask;

  assign inj_hit   = armed_q && accept && (wr_idx == inj_pos_q);
  // Bit indices past the codeword width consume the arm without flipping.
  assign flip_mask = (inj_bit_q < 5'(CW_W)) ? (cw_t'(1) << inj_bit_q) : '0;
  assign cw_wr     = inj_hit ? (cw_enc ^ flip_mask) : cw_enc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q   <= 1'b0;
      inj_pos_q <= '0;
      inj_bit_q <= '0;
    end else if (inj_arm) begin
      armed_q   <= 1'b1;
      inj_pos_q <= inj_pos;
      inj_bit_q <= inj_bit;
    end else if (inj_hit) begin
      armed_q   <= 1'b0;
    end
  end
`else
  assign cw_wr = cw_enc;
`endif

  always_comb begin
    out_tile = '0;
    for (int k = 0; k < TILE_N; k++) begin
      out_tile[k*CW_W +: CW_W] = bank_cw[rd_bank][k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < TILE_N; k++) begin
          bank_cw[b][k] <= '0;
        end
        bank_ovf[b] <= '0;
      end
    end else if (accept) begin
      bank_cw[wr_bank][wr_idx]  <= cw_wr;
      bank_ovf[wr_bank][wr_idx] <= ovf_enc;
    end
  end

  // A flush only rewinds the fill pointer; stale partial data is overwritten
  // before the bank can ever complete.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx  <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      tag_q   <= '0;
      state_q <= FULL_EMPTY;
    end else begin
      state_q <= state_d;
      if (flush) begin
        wr_idx <= '0;
      end else if (accept) begin
        wr_idx <= wr_idx + 1'b1;
      end
      if (complete) begin
        wr_bank <= ~wr_bank;
      end
      if (out_hs) begin
        rd_bank <= ~rd_bank;
        tag_q   <= tag_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FULL_EMPTY: if (complete) state_d = FULL_ONE;
      FULL_ONE: begin
        if (complete && !out_hs)      state_d = FULL_TWO;
        else if (out_hs && !complete) state_d = FULL_EMPTY;
      end
      FULL_TWO:   if (out_hs) state_d = FULL_ONE;
      default:    state_d = FULL_EMPTY;
    endcase
  end

endmodule

// File: tb/tb_an_encoder_n37_4x4.sv
// Scoreboard bench for an_encoder_n37_4x4: a tile-level model queues expected
// tiles as messages are accepted; a monitor pops them on each output handshake.
module tb_an_encoder_n37_4x4;

  localparam int TAG_W = 8;

  logic                clk;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [12:0]         in_msg;
  logic                flush;
  logic                out_valid;
  logic                out_ready;
  logic [287:0]        out_tile;
  logic [15:0]         out_ovf;
  logic [TAG_W-1:0]    out_tag;
`ifdef AN_ENC_ERRINJ_EN
  logic                inj_arm;
  logic [3:0]          inj_pos;
  logic [4:0]          inj_bit;
`endif

  an_encoder_n37_4x4 #(.TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_msg    (in_msg),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_tile  (out_tile),
    .out_ovf   (out_ovf),
    .out_tag   (out_tag)
`ifdef AN_ENC_ERRINJ_EN
    ,
    .inj_arm   (inj_arm),
    .inj_pos   (inj_pos),
    .inj_bit   (inj_bit)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [287:0] tile;
    logic [15:0]  ovf;
    logic [7:0]   tag;
  } exp_t;

  exp_t         exp_q[$];
  int           tests = 0;
  int           fails = 0;

  int           m_idx;
  logic [287:0] m_tile;
  logic [15:0]  m_ovf;
  int           m_tag;
  bit           m_armed;
  int           m_pos;
  int           m_bit;

  task automatic chk(input string name, input logic [287:0] act, input logic [287:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Tile-level reference: codeword = msg*37 if it fits, else 0 with flag.
  task automatic model_accept(input int msg);
    int cw;
    bit ov;
    exp_t e;
    ov = (msg > 7084);
    cw = ov ? 0 : msg * 37;
    if (m_armed && m_idx == m_pos) begin
      if (m_bit < 18) cw = cw ^ (1 << m_bit);
      m_armed = 0;
    end
    m_tile[m_idx*18 +: 18] = cw[17:0];
    m_ovf[m_idx] = ov;
    m_idx++;
    if (m_idx == 16) begin
      e.tile = m_tile;
      e.ovf  = m_ovf;
      e.tag  = m_tag[7:0];
      exp_q.push_back(e);
      m_tag  = (m_tag + 1) % 256;
      m_idx  = 0;
      m_tile = '0;
      m_ovf  = '0;
    end
  endtask

  task automatic send(input int msg);
    int w;
    w = 0;
    in_valid = 1'b1;
    in_msg   = msg[12:0];
    forever begin
      @(negedge clk);
      if (in_ready) begin
        model_accept(msg);
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      w++;
      if (w > 2000) begin
        tests++;
        fails++;
        $display("FAIL send_timeout msg=%0d in_ready stayed 0", msg);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_msg    = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
`ifdef AN_ENC_ERRINJ_EN
    inj_arm = 1'b0;
    inj_pos = '0;
    inj_bit = '0;
`endif
    exp_q.delete();
    m_idx = 0; m_tile = '0; m_ovf = '0; m_tag = 0; m_armed = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_tile", out_tile, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_out_tag", out_tag, 0);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
  endtask

  // Monitor: compares tiles on handshake and checks hold stability under backpressure.
  logic [287:0] held_tile;
  logic [15:0]  held_ovf;
  logic [7:0]   held_tag;
  bit           hold_v = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v = 0;
    end else begin
      if (hold_v) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_tile", out_tile, held_tile);
        chk("hold_ovf", out_ovf, held_ovf);
        chk("hold_tag", out_tag, held_tag);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_tile tag=%0d expected none", out_tag);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("tile", out_tile, e.tile);
          chk("ovf", out_ovf, e.ovf);
          chk("tag", out_tag, e.tag);
`ifndef AN_ENC_ERRINJ_EN
          begin
            int bad;
            int v;
            bad = 0;
            for (int k = 0; k < 16; k++) begin
              v = int'(out_tile[k*18 +: 18]);
              if (v % 37 != 0) bad++;
            end
            chk("cw_mod37_nonzero_count", bad, 0);
          end
`endif
        end
      end
      hold_v    = out_valid && !out_ready;
      held_tile = out_tile;
      held_ovf  = out_ovf;
      held_tag  = out_tag;
    end
  end

  initial begin
    do_reset();

    // Tile of 0..15 with latency check on the 16th accept.
    for (int i = 0; i < 15; i++) send(i);
    chk("valid_before_16th", out_valid, 0);
    send(15);
    chk("valid_after_16th", out_valid, 1);
    drain();

    // Overflow boundary.
    send(7084);
    send(7085);
    for (int i = 2; i < 16; i++) send($urandom_range(0, 7084));
    drain();

    // Backpressure: two tiles fill, third stalls.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 32; i++) send($urandom_range(0, 8191));
    in_valid = 1'b1;
    in_msg   = 13'd123;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("stall_out_valid", out_valid, 1);
    chk("stall_out_tag", out_tag, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send($urandom_range(0, 8191));
    for (int i = 0; i < 8; i++) send($urandom_range(0, 8191));
    drain();

    // Flush discards a partial tile and blocks acceptance that cycle.
    for (int i = 0; i < 5; i++) send(2000 + i);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_msg   = 13'd999;
    @(negedge clk);
    chk("flush_in_ready", in_ready, 0);
    m_idx = 0; m_tile = '0; m_ovf = '0;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 16; i++) send(100 + i);
    drain();

    // Random backpressure with idle gaps.
    fork
      begin
        for (int c = 0; c < 500; c++) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
      begin
        for (int i = 0; i < 64; i++) begin
          send($urandom_range(0, 8191));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Long stream forcing the tag to wrap.
    for (int t = 0; t < 257; t++) begin
      for (int i = 0; i < 16; i++) send($urandom_range(0, 8191));
    end
    drain();

`ifdef AN_ENC_ERRINJ_EN
    inj_arm = 1'b1; inj_pos = 4'd5; inj_bit = 5'd3;
    m_armed = 1; m_pos = 5; m_bit = 3;
    @(posedge clk); #1;
    inj_arm = 1'b0;
    for (int i = 0; i < 32; i++) send(1);
    drain();
    inj_arm = 1'b1; inj_pos = 4'd2; inj_bit = 5'd20;
    m_armed = 1; m_pos = 2; m_bit = 20;
    @(posedge clk); #1;
    inj_arm = 1'b0;
    for (int i = 0; i < 16; i++) send(3);
    drain();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
